// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULTU/DIVU engine that writes the HI/LO pair.
// Shift-add multiply and restoring divide retire one bit per clock.
// The start/busy/done handshake lets the hazard unit stall MFHI/MFLO.
// Optional build macro SIGNED_MULDIV_EN widens op to 2 bits. When op[1]=1 the
// unit performs signed MULT/DIV on magnitudes and fixes the sign at commit.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SIGNED_MULDIV_EN
  input  logic [1:0]       op,
`else
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             div_reg;      // latched op: 1 = divide
  logic [WIDTH-1:0] operand_reg;  // multiplicand or divisor
  logic [WIDTH-1:0] acc_hi_reg;   // P (multiply) or R (divide)
  logic [WIDTH-1:0] acc_lo_reg;   // M (multiply) or Q (divide)
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             div_zero_reg;

  logic             op_div;
  logic             accept;
  logic             start_dz;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Iteration datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef SIGNED_MULDIV_EN
  logic             a_neg, b_neg;
  logic             neg_lo_reg;   // negate quotient / product
  logic             neg_hi_reg;   // negate remainder
  logic [2*WIDTH-1:0] prod_neg;

  assign op_div = op[0];
  assign a_neg  = op[1] & src_a[WIDTH-1];
  assign b_neg  = op[1] & src_b[WIDTH-1];
  assign a_mag  = a_neg ? -src_a : src_a;
  assign b_mag  = b_neg ? -src_b : src_b;
`else
  assign op_div = op;
  assign a_mag  = src_a;
  assign b_mag  = src_b;
`endif

  // A request is taken in IDLE and also in FIN so back-to-back ops lose no cycle
  assign accept    = start && (state_reg == IDLE || state_reg == FIN);
  assign start_dz  = op_div && (src_b == '0);
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == FIN);
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  // One multiply step and one restoring-divide step, selected by the latched op
  always_comb begin
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

    div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, operand_reg});
    // The true difference is below the divisor, so it fits in WIDTH bits
    div_hi_next = div_ge ? (div_shift[WIDTH-1:0] - operand_reg) : div_shift[WIDTH-1:0];
    div_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};

    step_hi     = div_reg ? div_hi_next : mul_hi_next;
    step_lo     = div_reg ? div_lo_next : mul_lo_next;
  end

`ifdef SIGNED_MULDIV_EN
  // Apply result signs to the magnitude result as it is committed
  always_comb begin
    res_hi   = step_hi;
    res_lo   = step_lo;
    prod_neg = -{step_hi, step_lo};
    if (div_reg) begin
      if (neg_lo_reg) res_lo = -step_lo;
      if (neg_hi_reg) res_hi = -step_hi;
    end else if (neg_lo_reg) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

  // Sign flags captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
    end else if (accept) begin
      neg_lo_reg <= a_neg ^ b_neg;
      neg_hi_reg <= a_neg;
    end
  end
`else
  // Unsigned build: the iterated result is the final result
  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: divide-by-zero skips RUN and finishes on the next edge
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = start_dz ? FIN : RUN;
      RUN:  if (last_iter) state_next = FIN;
      FIN:  begin
        if (start) state_next = start_dz ? FIN : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration and HI/LO commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      div_reg      <= 1'b0;
      operand_reg  <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg      <= '0;
      div_reg      <= op_div;
      operand_reg  <= op_div ? b_mag : a_mag;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= op_div ? a_mag : b_mag;
      div_zero_reg <= start_dz;
      if (start_dz) begin
        hi_reg <= src_a;
        lo_reg <= '1;
      end
    end else if (state_reg == RUN) begin
      cnt_reg    <= cnt_reg + 1'b1;
      acc_hi_reg <= step_hi;
      acc_lo_reg <= step_lo;
      if (last_iter) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: scoreboard of expected HI/LO/div_zero/done-cycle
// entries pushed at start and popped by a monitor on every done pulse.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
    int           id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int txn_id = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference results from plain arithmetic
  task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    ed = 1'b0;
    if (!o) begin
      eh = p[63:32];
      el = p[31:0];
    end else if (b == '0) begin
      eh = a; el = '1; ed = 1'b1;
    end else begin
      eh = a % b; el = a / b;
    end
  endtask

  // Called 1 time unit after a rising edge; drives start for one cycle
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                       input bit expect_it);
    exp_t e;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (expect_it) begin
      e.hi = eh; e.lo = el; e.dz = ed;
      e.due = cyc + (ed ? 1 : 33);
      e.id = txn_id++;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    op = 1'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic issue_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic ed;
    model(o, a, b, eh, el, ed);
    issue(o, a, b, eh, el, ed, 1'b1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() > 0 && i < 100) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      check_val("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("txn %0d cycle %0d hi=0x%08h lo=0x%08h div_zero=%0b", e.id, cyc, hi, lo, div_zero);
        check_val("hi", 64'(hi), 64'(e.hi));
        check_val("lo", 64'(lo), 64'(e.lo));
        check_val("div_zero", 64'(div_zero), 64'(e.dz));
        check_val("done_cycle", 64'(cyc), 64'(e.due));
        check_val("busy_at_done", 64'(busy), 64'd0);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_dz", 64'(div_zero), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU 7 x 6 with busy window check
    n = cyc;
    issue(1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      check_val("busy_window", 64'(busy), 64'((cyc >= n + 1) && (cyc <= n + 32)));
    end
    wait_idle();

    // MULTU all-ones
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    wait_idle();

    // Start ignored mid-MULTU; hi/lo hold the previous result meanwhile
    n = cyc;
    issue_model(1'b0, 32'h0001_2345, 32'h0006_789A);
    repeat (9) @(posedge clk);
    #1;
    check_val("hold_hi", 64'(hi), 64'(last_hi));
    check_val("hold_lo", 64'(lo), 64'(last_lo));
    issue(1'b0, 32'd99, 32'd99, '0, '0, 1'b0, 1'b0);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    // DIVU 100/7, then DIVU 9/3 started in the FIN cycle
    n = cyc;
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    repeat (32) @(posedge clk);
    #1;
    check_val("fin_done", 64'(done), 64'd1);
    issue(1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b1);
    wait_idle();

    // Divide by zero
    issue(1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();
    // div_zero clears on the next start
    issue_model(1'b1, 32'hFFFF_FFFF, 32'd1);
    #1;
    check_val("dz_cleared", 64'(div_zero), 64'd0);
    wait_idle();

    // Random operations against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      issue_model(1'(i), $urandom, (i == 5) ? 32'($urandom_range(1, 300)) : $urandom);
      wait_idle();
    end

    // Reset in the middle of a DIVU
    n = cyc;
    issue(1'b1, 32'd1000, 32'd3, '0, '0, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_done", 64'(done), 64'd0);
    check_val("midrst_dz", 64'(div_zero), 64'd0);
    check_val("midrst_hi", 64'(hi), 64'd0);
    check_val("midrst_lo", 64'(lo), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("post_rst_busy", 64'(busy), 64'd0);
    issue(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
